// File: rtl/sbox_layer_seq.sv
// ASCON substitution layer, NSBOX Sboxes time-multiplexed over 64 columns.
// Optional abort input when SBOX_SEQ_ABORT_EN is defined.

module Sbox (
    input  logic [4:0] Sbox_in_i,
    output logic [4:0] Sbox_out_o
);
    // Bitsliced ASCON chi-based Sbox; x0 is the MSB.
    logic [4:0] w_a;
    logic [4:0] w_b;

    assign w_a[0] = Sbox_in_i[4] ^ Sbox_in_i[0];
    assign w_a[1] = Sbox_in_i[3];
    assign w_a[2] = Sbox_in_i[2] ^ Sbox_in_i[3];
    assign w_a[3] = Sbox_in_i[1];
    assign w_a[4] = Sbox_in_i[0] ^ Sbox_in_i[1];

    assign w_b[0] = w_a[0] ^ (~w_a[1] & w_a[2]);
    assign w_b[1] = w_a[1] ^ (~w_a[2] & w_a[3]);
    assign w_b[2] = w_a[2] ^ (~w_a[3] & w_a[4]);
    assign w_b[3] = w_a[3] ^ (~w_a[4] & w_a[0]);
    assign w_b[4] = w_a[4] ^ (~w_a[0] & w_a[1]);

    assign Sbox_out_o[4] = w_b[0] ^ w_b[4];
    assign Sbox_out_o[3] = w_b[1] ^ w_b[0];
    assign Sbox_out_o[2] = ~w_b[2];
    assign Sbox_out_o[1] = w_b[3] ^ w_b[2];
    assign Sbox_out_o[0] = w_b[4];
endmodule

module sbox_layer_seq #(
    parameter int NSBOX = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [319:0] state_i,
`ifdef SBOX_SEQ_ABORT_EN
    input  logic         abort_i,
`endif
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int NCOL = 64 / NSBOX;
    localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t          r_fsm;
    logic [CW-1:0] r_cnt;
    logic [319:0]  r_state;
    logic          r_busy;
    logic          r_done;

    logic [5:0]    w_col  [NSBOX];
    logic [4:0]    w_sin  [NSBOX];
    logic [4:0]    w_sout [NSBOX];
    logic [319:0]  w_next;

    // Bit j of xi lives at index {4-i, j} of the packed state.
    always_comb begin
        for (int k = 0; k < NSBOX; k++) begin
            w_col[k] = 6'(int'(r_cnt) * NSBOX + k);
            w_sin[k] = {r_state[{3'd4, w_col[k]}],
                        r_state[{3'd3, w_col[k]}],
                        r_state[{3'd2, w_col[k]}],
                        r_state[{3'd1, w_col[k]}],
                        r_state[{3'd0, w_col[k]}]};
        end
    end

    for (genvar g = 0; g < NSBOX; g++) begin : g_sbox
        Sbox u_sbox (
            .Sbox_in_i  (w_sin[g]),
            .Sbox_out_o (w_sout[g])
        );
    end

    always_comb begin
        w_next = r_state;
        for (int k = 0; k < NSBOX; k++) begin
            {w_next[{3'd4, w_col[k]}],
             w_next[{3'd3, w_col[k]}],
             w_next[{3'd2, w_col[k]}],
             w_next[{3'd1, w_col[k]}],
             w_next[{3'd0, w_col[k]}]} = w_sout[k];
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fsm   <= IDLE;
            r_cnt   <= '0;
            r_state <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (start_i) begin
                        r_state <= state_i;
                        r_cnt   <= '0;
                        r_fsm   <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
`ifdef SBOX_SEQ_ABORT_EN
                    if (abort_i) begin
                        r_fsm  <= IDLE;
                        r_cnt  <= '0;
                        r_busy <= 1'b0;
                    end else
`endif
                    begin
                        r_state <= w_next;
                        if (r_cnt == LAST) begin
                            r_fsm  <= DONE;
                            r_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    r_fsm  <= IDLE;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_fsm  <= IDLE;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
endmodule

// File: tb/tb_sbox_layer_seq.sv
// Self-checking bench for sbox_layer_seq with NSBOX = 4, 1 and 64.
// Abort scenarios are compiled in when SBOX_SEQ_ABORT_EN is defined.

module tb_sbox_layer_seq;
    localparam int NS [3] = '{4, 1, 64};

    localparam logic [4:0] STAB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    localparam logic [63:0] Z = 64'h0;
    localparam logic [63:0] O = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] T = 64'h8000_0000_0000_0000;

    typedef struct {
        string        nm;
        logic [319:0] st;
        logic [319:0] ex;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [2:0]   start_v = '0;
    logic [319:0] state_in = '0;
    logic [319:0] so [3];
    logic [2:0]   busy;
    logic [2:0]   done;
`ifdef SBOX_SEQ_ABORT_EN
    logic [2:0]   abort_v = '0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sbox_layer_seq #(.NSBOX(4)) u_n4 (
        .clock_i (clk), .resetb_i (rstn), .start_i (start_v[0]),
        .state_i (state_in),
`ifdef SBOX_SEQ_ABORT_EN
        .abort_i (abort_v[0]),
`endif
        .state_o (so[0]), .busy_o (busy[0]), .done_o (done[0]));

    sbox_layer_seq #(.NSBOX(1)) u_n1 (
        .clock_i (clk), .resetb_i (rstn), .start_i (start_v[1]),
        .state_i (state_in),
`ifdef SBOX_SEQ_ABORT_EN
        .abort_i (abort_v[1]),
`endif
        .state_o (so[1]), .busy_o (busy[1]), .done_o (done[1]));

    sbox_layer_seq #(.NSBOX(64)) u_n64 (
        .clock_i (clk), .resetb_i (rstn), .start_i (start_v[2]),
        .state_i (state_in),
`ifdef SBOX_SEQ_ABORT_EN
        .abort_i (abort_v[2]),
`endif
        .state_o (so[2]), .busy_o (busy[2]), .done_o (done[2]));

    // Reference: split into five lanes, apply table Sbox per column.
    function automatic logic [319:0] layer_ref(input logic [319:0] s);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  c;
        logic [4:0]  r;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
        for (int j = 0; j < 64; j++) begin
            c = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            r = STAB[c];
            for (int i = 0; i < 5; i++) y[i][j] = r[4 - i];
        end
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int w = 0; w < 10; w++) s[w * 32 +: 32] = $urandom();
        return s;
    endfunction

    task automatic chk_st(input string nm, input logic [319:0] act,
                          input logic [319:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Start the selected instances and watch 80 cycles.
    // restart re-pulses start with a different state at cycles 3, 16, 17.
    task automatic run_layer(input string nm, input logic [319:0] st,
                             input logic [319:0] exp,
                             input logic [2:0] mask, input bit restart);
        int lat [3];
        int nd  [3];
        int b1  [3];
        lat = '{0, 0, 0};
        nd  = '{0, 0, 0};
        state_in = st;
        start_v  = mask;
        @(posedge clk); #1;
        start_v = '0;
        for (int i = 0; i < 3; i++) b1[i] = int'(busy[i]);
        for (int c = 1; c <= 80; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    nd[i]++;
                    if (lat[i] == 0) lat[i] = c;
                end
            end
            start_v = '0;
            if (restart && (c == 3 || c == 16 || c == 17)) begin
                state_in = st ^ rand_state() ^ 320'h1;
                start_v  = mask;
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                chk_int($sformatf("%s/n%0d busy", nm, NS[i]), b1[i], 1);
                chk_int($sformatf("%s/n%0d latency", nm, NS[i]),
                        lat[i], 64 / NS[i] + 1);
                chk_int($sformatf("%s/n%0d done count", nm, NS[i]),
                        nd[i], 1);
                chk_st($sformatf("%s/n%0d state", nm, NS[i]), so[i], exp);
                chk_int($sformatf("%s/n%0d idle", nm, NS[i]),
                        int'(busy[i]), 0);
            end
        end
    endtask

    initial begin
        vec_t         tv [4];
        logic [319:0] s;
        int           ndone;

        tv[0] = '{"zero", {Z, Z, Z, Z, Z}, {Z, Z, O, Z, Z}};
        tv[1] = '{"ones", {O, O, O, O, O}, {O, Z, O, O, O}};
        tv[2] = '{"col0", {Z, Z, 64'h1, Z, 64'h1},
                  {64'h1, Z, O, Z, 64'h1}};
        tv[3] = '{"col63", {Z, T, Z, Z, Z},
                  {T, T, 64'h7FFF_FFFF_FFFF_FFFF, T, T}};

        #1;
        for (int i = 0; i < 3; i++) begin
            chk_st($sformatf("reset/n%0d state", NS[i]), so[i], '0);
            chk_int($sformatf("reset/n%0d busy", NS[i]), int'(busy[i]), 0);
            chk_int($sformatf("reset/n%0d done", NS[i]), int'(done[i]), 0);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        for (int v = 0; v < 4; v++)
            run_layer(tv[v].nm, tv[v].st, tv[v].ex, 3'b111, 1'b0);

        for (int r = 0; r < 8; r++) begin
            s = rand_state();
            run_layer($sformatf("rand%0d", r), s, layer_ref(s), 3'b111, 1'b0);
        end

        s = rand_state();
        run_layer("restart", s, layer_ref(s), 3'b001, 1'b1);

        // Reset at cycle 5 of a layer, then a fresh start right after.
        state_in = rand_state();
        start_v  = 3'b111;
        @(posedge clk); #1;
        start_v = '0;
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_st($sformatf("midrst/n%0d state", NS[i]), so[i], '0);
            chk_int($sformatf("midrst/n%0d busy", NS[i]), int'(busy[i]), 0);
        end
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ndone += int'(done[0]) + int'(done[1]) + int'(done[2]);
        end
        rstn = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            ndone += int'(done[0]) + int'(done[1]) + int'(done[2]);
        end
        chk_int("midrst no done", ndone, 0);
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        s = rand_state();
        run_layer("postrst", s, layer_ref(s), 3'b111, 1'b0);

`ifdef SBOX_SEQ_ABORT_EN
        state_in = rand_state();
        start_v  = 3'b011;
        @(posedge clk); #1;
        start_v = '0;
        repeat (7) @(posedge clk);
        #1 abort_v = 3'b011;
        @(posedge clk); #1;
        abort_v = '0;
        chk_int("abort/n4 busy", int'(busy[0]), 0);
        chk_int("abort/n1 busy", int'(busy[1]), 0);
        ndone = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            ndone += int'(done[0]) + int'(done[1]);
        end
        chk_int("abort no done", ndone, 0);

        state_in = rand_state();
        start_v  = 3'b100;
        @(posedge clk); #1;
        start_v = '0;
        abort_v = 3'b100;
        @(posedge clk); #1;
        abort_v = '0;
        chk_int("abort last/n64 busy", int'(busy[2]), 0);
        chk_int("abort last/n64 done", int'(done[2]), 0);

        s = rand_state();
        run_layer("postabort", s, layer_ref(s), 3'b111, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sbox_layer_seq.md
SBOX_LAYER_SEQ -- requirements
Module: sbox_layer_seq

Interface
REQ-001 The block SHALL have parameter NSBOX, default 4, giving the number of Sbox instances evaluated per cycle; legal values are 1, 2, 4, 8, 16, 32 and 64.
REQ-002 The block SHALL have port clock_i, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port resetb_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start_i, input, 1 bit: request one substitution layer on state_i.
REQ-005 The block SHALL have port state_i, input, 320 bits: the ASCON state, with x0 in [319:256], x1 in [255:192], x2 in [191:128], x3 in [127:64] and x4 in [63:0].
REQ-006 The block SHALL have port state_o, output, 320 bits: the substituted state, using the same packing as state_i.
REQ-007 The block SHALL have port busy_o, output, 1 bit: high while the layer is in progress.
REQ-008 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse when state_o becomes valid.
REQ-009 The block SHALL have port abort_i, input, 1 bit: cancel the layer in progress; this port is present only when SBOX_SEQ_ABORT_EN is defined.

Function
REQ-010 The block SHALL instantiate NSBOX copies of the existing Sbox module and time-multiplex them over the 64 state columns.
REQ-011 Column j SHALL be formed as {x0[j], x1[j], x2[j], x3[j], x4[j]}, with x0 on Sbox_in_i[4].
- The 5-bit Sbox result SHALL be written back to bit j of x0..x4 in the same bit order.
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE, start_i=1 SHALL load state_i into the working register, clear column counter cnt to 0, and move the FSM to RUN.
REQ-014 In RUN, each cycle SHALL substitute columns cnt*NSBOX through cnt*NSBOX+NSBOX-1 in place and then increment cnt.
REQ-015 When cnt equals 64/NSBOX-1 in RUN, the FSM SHALL move to DONE on the next edge.
- cnt is log2(64/NSBOX) bits wide, with a minimum of 1 bit.
- cnt SHALL NOT wrap back into RUN.
REQ-016 DONE SHALL last exactly one cycle with done_o=1, and the FSM SHALL then return to IDLE unconditionally.
REQ-017 busy_o SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 Latency: if start_i is sampled on edge N, done_o SHALL be high in the cycle following edge N+64/NSBOX.
REQ-019 state_o SHALL be driven directly from the working register.
- state_o is valid from the done_o cycle and SHALL hold its value until the next accepted start_i.
- Intermediate values while busy_o=1 are not valid.
REQ-020 start_i SHALL be ignored while busy_o=1, so no restart and no reload occur.
- start_i in the DONE cycle SHALL also be ignored; a new start is accepted only in IDLE.
REQ-021 With NSBOX=64, RUN SHALL last exactly one cycle.

Reset
REQ-022 When resetb_i=0, the block SHALL asynchronously force: FSM to IDLE, cnt to 0, working register to 0, busy_o to 0 and done_o to 0.
- state_o therefore reads 320'h0 during reset.
REQ-023 Reset asserted mid-RUN SHALL discard the partial result, and no done_o SHALL be produced for the interrupted layer.
REQ-024 After resetb_i deasserts, start_i SHALL be accepted on the first rising edge.

Configuration
REQ-025 When macro SBOX_SEQ_ABORT_EN is defined, abort_i SHALL exist.
- abort_i=1 in RUN SHALL return the FSM to IDLE on the next edge, clear cnt, and produce no done_o.
- The working register keeps its partially substituted contents.
- abort_i SHALL take priority over the final-column transition to DONE.
- abort_i SHALL be ignored in IDLE and DONE.
REQ-026 When SBOX_SEQ_ABORT_EN is undefined, abort_i SHALL be absent and every accepted start SHALL complete.

Verification
REQ-027 Scenario, all-zero state, NSBOX=4: state_i=0 plus a start pulse -> done_o pulses 17 cycles after the start edge, with x2=64'hFFFF_FFFF_FFFF_FFFF and x0, x1, x3, x4 = 0 (S(0x00)=0x04).
REQ-028 Scenario, all-ones state: state_i = all ones -> x0, x2, x3, x4 = all ones and x1=0 (S(0x1F)=0x17).
REQ-029 Scenario, single column: only column 0 = 0x05 with all other columns 0 -> column 0 = 0x15 and every other column = 0x04; repeat with column 63 = 0x08 -> column 63 = 0x1B.
REQ-030 Scenario, start while busy: pulse start_i again at cycles 3 and 16 after the first start with a different state_i -> a single done_o, with the result matching the first state only.
REQ-031 Scenario, reset mid-RUN: drop resetb_i at cycle 5 -> state_o=0 and busy_o=0 immediately, with no done_o; a fresh start afterwards completes normally.
REQ-032 Scenario, abort (SBOX_SEQ_ABORT_EN defined): assert abort_i at cycle 8 -> busy_o=0 after the next edge and no done_o; then sweep NSBOX=1 and NSBOX=64 and check latencies of 65 and 2 cycles.
